wb_cmd_master: RTL and testbench

Wishbone classic single-transfer initiator that drives the user-area slave bus from a simple command/response stream. It turns one command into one Wishbone read or write and returns the read data or a timeout error. It lets on-chip logic such as a test sequencer or logic-analyzer-driven controller exercise peripherals on the same bus the management SoC uses. It sits on the initiator side of the user project's Wishbone port, opposite the peripheral slave.

---
 rtl/wb_cmd_master.sv | 160 ++++++++++++++++
 tb/tb_wb_cmd_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master
// Wishbone classic single-transfer initiator driven by a command/response
// stream. Each accepted command becomes exactly one Wishbone read or write.
// Each command returns either the read data or a timeout error.
//
// Handshakes: a beat moves on a rising edge where valid & ready are both 1.
// A producer keeps valid and its payload steady until that edge. Ready may
// depend on state but never on the valid of the same channel.
//
// Ports
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command channel (cmd_we, cmd_adr, cmd_dat, cmd_sel)
//   rsp_valid/rsp_ready    response channel (rsp_dat, rsp_err)
//   wbm_*                  Wishbone initiator signals
//   busy                   1 while a command is in flight (state != IDLE)
//   txn_count              completed transfers (acked or timed out), wraps
//   state_dbg              current FSM state for checkers (0 IDLE, 1 BUS, 2 RESP)
module wb_cmd_master #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy,
   output logic [15:0] txn_count,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   // Last count value before the transfer is abandoned. The counter starts at
   // 0 in the first BUS cycle, so cyc/stb stay high for exactly TIMEOUT cycles.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] tmo_q, tmo_d;
   logic        cyc_d, stb_d, we_d;
   logic [3:0]  sel_d;
   logic [31:0] adr_d, dat_o_d;
   logic        rsp_valid_d, rsp_err_d;
   logic [31:0] rsp_dat_d;
   logic [15:0] txn_d;

   assign cmd_ready = (state_q == IDLE);
   assign state_dbg = state_q;

   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      cyc_d       = wbm_cyc_o;
      stb_d       = wbm_stb_o;
      we_d        = wbm_we_o;
      sel_d       = wbm_sel_o;
      adr_d       = wbm_adr_o;
      dat_o_d     = wbm_dat_o;
      rsp_valid_d = rsp_valid;
      rsp_err_d   = rsp_err;
      rsp_dat_d   = rsp_dat;
      txn_d       = txn_count;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               we_d    = cmd_we;
               adr_d   = cmd_adr;
               dat_o_d = cmd_dat;
               sel_d   = cmd_sel;
               tmo_d   = 16'd0;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               state_d = BUS;
            end
         end
         BUS: begin
            // Ack is checked first so an ack on the expiry cycle still
            // completes normally.
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_dat_d   = wbm_we_o ? 32'd0 : wbm_dat_i;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               txn_d       = txn_count + 16'd1;
               state_d     = RESP;
            end else if (tmo_q == TMO_LAST) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_dat_d   = 32'd0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               txn_d       = txn_count + 16'd1;
               state_d     = RESP;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         tmo_q     <= 16'd0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= 4'd0;
         wbm_adr_o <= 32'd0;
         wbm_dat_o <= 32'd0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_dat   <= 32'd0;
         txn_count <= 16'd0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         wbm_cyc_o <= cyc_d;
         wbm_stb_o <= stb_d;
         wbm_we_o  <= we_d;
         wbm_sel_o <= sel_d;
         wbm_adr_o <= adr_d;
         wbm_dat_o <= dat_o_d;
         rsp_valid <= rsp_valid_d;
         rsp_err   <= rsp_err_d;
         rsp_dat   <= rsp_dat_d;
         txn_count <= txn_d;
         busy      <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master with TIMEOUT = 8.
// The reference model is transfer-level. A command whose slave acks in BUS
// cycle k (1..TIMEOUT) holds cyc/stb for k cycles and completes normally.
// If the slave never acks, cyc/stb are held for TIMEOUT cycles and the
// command ends with an error. Expected read data goes into exp_q.
module tb_wb_cmd_master;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i, busy;
  logic [15:0] txn_count;
  logic [1:0]  state_dbg;

  logic [31:0] exp_q[$];
  logic [15:0] model_count;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cycle = 0;
  int          last_hs = 0;

  wb_cmd_master #(.TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .busy(busy), .txn_count(txn_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete command. ack_at = BUS cycle in which the slave acks
  // (0 = never). rsp_wait = cycles rsp_ready is held low once rsp_valid is
  // up. hold_cmd keeps cmd_valid asserted during that wait.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                        input int rsp_wait, input bit hold_cmd);
    bit          exp_err;
    int          exp_cyc, cyc_cnt;
    bit          bus_ok, hold_ok;
    logic [31:0] exp_dat, held_dat;
    logic        held_err;
    exp_err = (ack_at < 1) || (ack_at > TMO);
    exp_cyc = exp_err ? TMO : ack_at;
    exp_q.push_back((we || exp_err) ? 32'd0 : rdata);

    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    else n_pass++;
    tick();
    last_hs = cycle;
    cmd_valid = 1'b0;

    cyc_cnt = 0; bus_ok = 1;
    for (int c = 1; c <= TMO + 4; c++) begin
      if (wbm_cyc_o !== 1'b1) break;
      cyc_cnt++;
      if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr || wbm_dat_o !== dat ||
          wbm_sel_o !== sel || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1)
        bus_ok = 0;
      wbm_ack_i = (c == ack_at);
      wbm_dat_i = (c == ack_at) ? rdata : $urandom;
      tick();
    end
    wbm_ack_i = 1'b0;
    if (exp_err || !we) model_count = model_count; // count advances for every completion
    model_count = model_count + 16'd1;

    n_checks++;
    if (cyc_cnt !== exp_cyc) $display("FAIL cyc_cycles: got %0d want %0d", cyc_cnt, exp_cyc);
    else n_pass++;
    n_checks++;
    if (!bus_ok) $display("FAIL bus_signals: got unstable/incorrect want we=%b adr=%h dat=%h sel=%h", we, adr, dat, sel);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== 1'b1 || wbm_stb_o !== 1'b0) $display("FAIL rsp_valid_rise: got valid=%b stb=%b want 1/0", rsp_valid, wbm_stb_o);
    else n_pass++;
    n_checks++;
    if (rsp_err !== exp_err) $display("FAIL rsp_err: got %b want %b", rsp_err, exp_err);
    else n_pass++;
    exp_dat = exp_q.pop_front();
    n_checks++;
    if (rsp_dat !== exp_dat) $display("FAIL rsp_dat: got %h want %h", rsp_dat, exp_dat);
    else n_pass++;
    n_checks++;
    if (txn_count !== model_count) $display("FAIL txn_count: got %h want %h", txn_count, model_count);
    else n_pass++;

    held_dat = rsp_dat; held_err = rsp_err; hold_ok = 1;
    for (int w = 0; w < rsp_wait; w++) begin
      rsp_ready = 1'b0;
      cmd_valid = hold_cmd;
      wbm_ack_i = 1'(($urandom_range(0, 1)));   // stray acks must be ignored
      wbm_dat_i = $urandom;
      tick();
      if (rsp_valid !== 1'b1 || rsp_dat !== held_dat || rsp_err !== held_err || cmd_ready !== 1'b0 ||
          wbm_cyc_o !== 1'b0 || txn_count !== model_count || busy !== 1'b1)
        hold_ok = 0;
    end
    wbm_ack_i = 1'b0;
    if (rsp_wait > 0) begin
      n_checks++;
      if (!hold_ok) $display("FAIL rsp_hold: got change during backpressure want stable dat=%h err=%b", held_dat, held_err);
      else n_pass++;
    end

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rsp_consume: got valid=%b ready=%b busy=%b want 0/1/0", rsp_valid, cmd_ready, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    model_count = 16'd0;
    tick();
    n_checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || wbm_sel_o !== 4'd0 ||
        wbm_adr_o !== 32'd0 || wbm_dat_o !== 32'd0)
      $display("FAIL reset_bus: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want all 0",
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 32'd0)
      $display("FAIL reset_rsp: got valid=%b err=%b dat=%h want 0", rsp_valid, rsp_err, rsp_dat);
    else n_pass++;
    n_checks++;
    if (txn_count !== 16'd0 || busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL reset_status: got count=%h busy=%b ready=%b want 0/0/1", txn_count, busy, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_bus();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0008; cmd_dat = $urandom; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();                       // now in the 2nd BUS cycle
    n_checks++;
    if (wbm_cyc_o !== 1'b1) $display("FAIL mid_bus_cyc: got %b want 1", wbm_cyc_o);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_err !== 1'b0 || txn_count !== model_count || busy !== 1'b0)
      $display("FAIL mid_bus_reset: got cyc=%b stb=%b valid=%b count=%h want 0/0/0/%h",
               wbm_cyc_o, wbm_stb_o, rsp_valid, txn_count, model_count);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL mid_bus_ready: got %b want 1", cmd_ready);
    else n_pass++;
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hBAD0_BAD0;
    repeat (3) tick();
    wbm_ack_i = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || txn_count !== model_count)
      $display("FAIL stray_ack: got valid=%b cyc=%b count=%h want 0/0/%h", rsp_valid, wbm_cyc_o, txn_count, model_count);
    else n_pass++;
  endtask

  task automatic test_write_zero_wait();
    do_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'h5555_AAAA, 0, 1'b0);
  endtask

  task automatic test_read_wait();
    do_txn(1'b0, 32'h3000_0008, $urandom, 4'hF, 4, 32'h1234_5678, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 32'h3000_0010, $urandom, 4'h3, 0, 32'hFFFF_0000, 0, 1'b0);
    do_txn(1'b0, 32'h3000_0014, $urandom, 4'hC, TMO, 32'h0BAD_CAFE, 0, 1'b0);
    do_txn(1'b1, 32'h3000_0018, 32'h0102_0304, 4'h1, 0, 32'h7777_7777, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 5, 1'b1);
    do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 32'h600D_D00D, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int prev;
    bit rate_ok;
    rate_ok = 1;
    do_txn(1'b1, 32'h3000_0100, $urandom, 4'hF, 1, 32'h0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      prev = last_hs;
      do_txn(1'(i % 2), $urandom, $urandom, 4'(($urandom_range(0, 15))), 1, $urandom, 0, 1'b0);
      if (last_hs - prev != 3) rate_ok = 0;
    end
    n_checks++;
    if (!rate_ok) $display("FAIL back_to_back_rate: got gap != 3 cycles want 3");
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      do_txn(1'(($urandom_range(0, 1))), $urandom, $urandom, 4'(($urandom_range(0, 15))),
             $urandom_range(0, TMO + 2), $urandom, $urandom_range(0, 3), 1'(($urandom_range(0, 1))));
    cmd_valid = 1'b0;
  endtask

  task automatic test_counter_wrap();
    // Counter preloaded near its limit so the wrap shows up in two transfers.
    force dut.txn_count = 16'hFFFE;
    #1;
    release dut.txn_count;
    model_count = 16'hFFFE;
    do_txn(1'b1, 32'h3000_0200, $urandom, 4'hF, 1, 32'h0, 0, 1'b0);
    n_checks++;
    if (txn_count !== 16'hFFFF) $display("FAIL count_ffff: got %h want ffff", txn_count);
    else n_pass++;
    do_txn(1'b0, 32'h3000_0204, $urandom, 4'hF, 1, 32'h0000_0042, 0, 1'b0);
    n_checks++;
    if (txn_count !== 16'h0000) $display("FAIL count_wrap: got %h want 0000", txn_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_bus();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_counter_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
